// File: rtl/cfg_loader_pkg.sv
// Shared types and constants for the configuration frame loader.
package cfg_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    CHECK
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam logic [7:0] CRC8_POLY         = 8'h07;

  // Payload bytes needed to carry a configuration of the given width.
  function automatic int nbytes(input int cfg_bits);
    return (cfg_bits + 7) / 8;
  endfunction

endpackage

// File: rtl/cfg_frame_loader_if.sv
// Byte-receiver input and committed-configuration output bundle of cfg_frame_loader.
interface cfg_frame_loader_if #(
  parameter int CFG_BITS = 52
);
  logic                rx_valid_i;
  logic [7:0]          rx_data_i;
  logic                rx_err_i;
  logic [CFG_BITS-1:0] cfg_bits_o;
  logic                cfg_valid_o;
  logic                cfg_load_o;
  logic                cfg_error_o;
  logic                busy_o;

  modport master (
    output rx_valid_i, rx_data_i, rx_err_i,
    input  cfg_bits_o, cfg_valid_o, cfg_load_o, cfg_error_o, busy_o
  );

  modport slave (
    input  rx_valid_i, rx_data_i, rx_err_i,
    output cfg_bits_o, cfg_valid_o, cfg_load_o, cfg_error_o, busy_o
  );
endinterface

// File: rtl/cfg_chk_step.sv
// One payload-byte step of the frame check: XOR by default, CRC-8 (poly 0x07,
// MSB-first) when CFG_LOADER_CRC8_EN is defined.
module cfg_chk_step
  import cfg_loader_pkg::*;
(
  input  logic [7:0] chk,
  input  logic [7:0] data,
  output logic [7:0] chk_next
);

`ifdef CFG_LOADER_CRC8_EN
  always_comb begin
    // NOTE: assign a default before the loop so every path writes chk_next and no latch is inferred.
    chk_next = chk ^ data;
    for (int i = 0; i < 8; i++) begin
      chk_next = chk_next[7] ? ({chk_next[6:0], 1'b0} ^ CRC8_POLY)
                             : {chk_next[6:0], 1'b0};
    end
  end
`else
  assign chk_next = chk ^ data;
`endif

endmodule

// File: rtl/cfg_frame_loader.sv
// Receives sync/payload/check frames byte-by-byte and atomically commits the
// payload as the fabric configuration. Check type selected by CFG_LOADER_CRC8_EN.
module cfg_frame_loader
  import cfg_loader_pkg::*;
#(
  parameter int         CFG_BITS       = 52,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 20000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  cfg_frame_loader_if.slave bus
);

  localparam int NBYTES    = nbytes(CFG_BITS);
  localparam int IDX_W     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CNT_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W     = (CNT_W_RAW > 0) ? CNT_W_RAW : 1;
  localparam int CNT_LAST_INT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_INT);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [7:0]          chk;
  logic [7:0]          chk_next;
  logic [CNT_W-1:0]    cnt;
  logic [CFG_BITS-1:0] staging;
  logic [CFG_BITS-1:0] cfg_bits;
  logic                cfg_valid;
  logic                cfg_load;
  logic                cfg_error;
  logic                timeout_hit;

  cfg_chk_step u_chk_step (
    .chk      (chk),
    .data     (bus.rx_data_i),
    .chk_next (chk_next)
  );

  // This silent cycle is the TIMEOUT_CYCLES-th one since the last accepted byte.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state     <= IDLE;
      idx       <= '0;
      chk       <= '0;
      cnt       <= '0;
      staging   <= '0;
      cfg_bits  <= '0;
      cfg_valid <= 1'b0;
      cfg_load  <= 1'b0;
      cfg_error <= 1'b0;
    end else begin
      cfg_load <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.rx_valid_i && bus.rx_data_i == SYNC_BYTE) begin
            state     <= PAYLOAD;
            idx       <= '0;
            chk       <= '0;
            cnt       <= '0;
            cfg_valid <= 1'b0;
          end
        end

        PAYLOAD, CHECK: begin
          if (bus.rx_err_i) begin
            // A byte arriving alongside a framing error is dropped with the frame.
            state     <= IDLE;
            cfg_error <= 1'b1;
          end else if (bus.rx_valid_i) begin
            cnt <= '0;
            if (state == PAYLOAD) begin
              // Bits beyond CFG_BITS in the last byte are dropped but still checked.
              for (int b = 0; b < CFG_BITS; b++) begin
                if (b / 8 == int'(idx)) staging[b] <= bus.rx_data_i[b % 8];
              end
              chk <= chk_next;
              idx <= idx + 1'b1;
              if (idx == IDX_LAST) state <= CHECK;
            end else begin
              if (bus.rx_data_i == chk) begin
                cfg_bits  <= staging;
                cfg_valid <= 1'b1;
                cfg_load  <= 1'b1;
                cfg_error <= 1'b0;
              end else begin
                cfg_error <= 1'b1;
              end
              state <= IDLE;
            end
          end else if (timeout_hit) begin
            state     <= IDLE;
            cfg_error <= 1'b1;
          end else if (cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cfg_bits_o  = cfg_bits;
  assign bus.cfg_valid_o = cfg_valid;
  assign bus.cfg_load_o  = cfg_load;
  assign bus.cfg_error_o = cfg_error;
  assign bus.busy_o      = (state != IDLE);

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Bench for cfg_frame_loader: directed frames pinned by literals, then random
// frames checked every cycle against a queue-based frame model.
module tb_cfg_frame_loader;

  localparam int         CFG_BITS = 52;
  localparam int         NB       = 7;
  localparam int         TO       = 40;
  localparam logic [7:0] SYNC     = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cfg_frame_loader_if #(.CFG_BITS(CFG_BITS)) bus ();

  cfg_frame_loader #(
    .CFG_BITS       (CFG_BITS),
    .SYNC_BYTE      (SYNC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame check computed directly from the payload byte list.
  function automatic logic [7:0] ref_check(input logic [7:0] p[$]);
    logic [7:0] c;
    c = 8'h00;
    foreach (p[i]) begin
      c = c ^ p[i];
`ifdef CFG_LOADER_CRC8_EN
      for (int k = 0; k < 8; k++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
`endif
    end
    return c;
  endfunction

  function automatic logic [CFG_BITS-1:0] pack(input logic [7:0] p[$]);
    logic [NB*8-1:0] w;
    w = '0;
    foreach (p[i]) w[8*i +: 8] = p[i];
    return w[CFG_BITS-1:0];
  endfunction

  // Behavioural model: a frame is "open" after SYNC, collects NB bytes, then judges the next.
  logic [CFG_BITS-1:0] m_bits = '0;
  bit                  m_valid, m_load, m_err, m_busy;
  logic [7:0]          m_q[$];
  int                  m_silent;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_bits = '0; m_valid = 0; m_load = 0; m_err = 0; m_busy = 0;
      m_q.delete(); m_silent = 0;
    end else begin
      m_load = 0;
      if (!m_busy) begin
        if (bus.rx_valid_i && bus.rx_data_i == SYNC) begin
          m_busy = 1; m_q.delete(); m_silent = 0; m_valid = 0;
        end
      end else if (bus.rx_err_i) begin
        m_busy = 0; m_err = 1;
      end else if (bus.rx_valid_i) begin
        m_silent = 0;
        if (m_q.size() < NB) m_q.push_back(bus.rx_data_i);
        else begin
          if (bus.rx_data_i == ref_check(m_q)) begin
            m_bits = pack(m_q); m_valid = 1; m_load = 1; m_err = 0;
          end else m_err = 1;
          m_busy = 0;
        end
      end else begin
        m_silent++;
        if (m_silent >= TO) begin m_busy = 0; m_err = 1; end
      end
    end
  end

  always @(negedge clk) begin
    check("cfg_bits",  bus.cfg_bits_o,  m_bits);
    check("cfg_valid", bus.cfg_valid_o, m_valid);
    check("cfg_load",  bus.cfg_load_o,  m_load);
    check("cfg_error", bus.cfg_error_o, m_err);
    check("busy",      bus.busy_o,      m_busy);
  end

  // Called at a negedge: present inputs for one cycle, return at the next negedge.
  task automatic step(input bit v, input logic [7:0] d, input bit e);
    bus.rx_valid_i = v; bus.rx_data_i = d; bus.rx_err_i = e;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] p[$], input logic [7:0] chk);
    step(1'b1, SYNC, 1'b0);
    foreach (p[i]) step(1'b1, p[i], 1'b0);
    step(1'b1, chk, 1'b0);
  endtask

  logic [7:0] good_p[$];
  logic [7:0] sync_p[$];
  logic [7:0] rp[$];

  initial begin
    bus.rx_valid_i = 1'b0; bus.rx_data_i = 8'h00; bus.rx_err_i = 1'b0;
    good_p = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h0F};
    sync_p = '{8'h01, 8'hA5, 8'h03, 8'h04, 8'h05, 8'h06, 8'h0F};
    repeat (3) @(negedge clk);
    check("reset_bits", bus.cfg_bits_o, 64'h0);
    check("reset_busy", bus.busy_o, 64'h0);
    rst = 1'b0;
    idle(2);

`ifndef CFG_LOADER_CRC8_EN
    check("model_xor_pin", ref_check(good_p), 64'h08);
`endif

    // Good frame.
    send_frame(good_p, ref_check(good_p));
    check("good_bits",  bus.cfg_bits_o,  64'hF_0605_0403_0201);
    check("good_valid", bus.cfg_valid_o, 64'h1);
    check("good_load",  bus.cfg_load_o,  64'h1);
    check("good_err",   bus.cfg_error_o, 64'h0);
    idle(1);
    check("good_load_1cyc", bus.cfg_load_o, 64'h0);

    // Bad check byte.
    send_frame(good_p, ref_check(good_p) ^ 8'h01);
    check("bad_err",   bus.cfg_error_o, 64'h1);
    check("bad_valid", bus.cfg_valid_o, 64'h0);
    check("bad_load",  bus.cfg_load_o,  64'h0);
    check("bad_bits",  bus.cfg_bits_o,  64'hF_0605_0403_0201);
    idle(1);

    // Idle noise, then a frame with SYNC as payload data.
    step(1'b1, 8'h00, 1'b0); step(1'b1, 8'hFF, 1'b0); step(1'b1, 8'h5A, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check("noise_busy", bus.busy_o, 64'h0);
    send_frame(sync_p, ref_check(sync_p));
    check("resync_bits", bus.cfg_bits_o,  64'hF_0605_0403_A501);
    check("resync_err",  bus.cfg_error_o, 64'h0);
    check("resync_load", bus.cfg_load_o,  64'h1);

    // Timeout boundary.
    step(1'b1, SYNC, 1'b0); step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0); step(1'b1, 8'h03, 1'b0);
    idle(TO - 1);
    check("to_busy_before", bus.busy_o, 64'h1);
    idle(1);
    check("to_busy_after", bus.busy_o,      64'h0);
    check("to_err",        bus.cfg_error_o, 64'h1);
    send_frame(good_p, ref_check(good_p));
    check("to_recover_err",   bus.cfg_error_o, 64'h0);
    check("to_recover_valid", bus.cfg_valid_o, 64'h1);

    // Error with a byte in the same cycle mid-payload.
    step(1'b1, SYNC, 1'b0); step(1'b1, 8'h01, 1'b0); step(1'b1, 8'h02, 1'b0);
    step(1'b1, 8'h33, 1'b1);
    check("abort_err",  bus.cfg_error_o, 64'h1);
    check("abort_busy", bus.busy_o,      64'h0);

    // Reset mid-frame.
    step(1'b1, SYNC, 1'b0); step(1'b1, 8'h01, 1'b0);
    bus.rx_valid_i = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    check("rst_bits",  bus.cfg_bits_o,  64'h0);
    check("rst_valid", bus.cfg_valid_o, 64'h0);
    check("rst_err",   bus.cfg_error_o, 64'h0);
    check("rst_busy",  bus.busy_o,      64'h0);
    rst = 1'b0;
    idle(1);

    // Random frames with gaps, corruption, errors and occasional timeouts.
    for (int f = 0; f < 300; f++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        for (int i = 0; i < int'($urandom_range(1, 4)); i++)
          step(1'b1, 8'($urandom), $urandom_range(0, 3) == 0);
      end
      rp.delete();
      for (int i = 0; i < NB; i++)
        rp.push_back(($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom));
      step(1'b1, SYNC, 1'b0);
      for (int i = 0; i <= NB; i++) begin
        int gap;
        logic [7:0] b;
        gap = int'($urandom_range(0, 3));
        if (kind == 1 && i == 3) gap = TO - 1;
        if (kind == 2 && i == 4) gap = TO;
        idle(gap);
        b = (i < NB) ? rp[i] : ref_check(rp);
        if (i == NB && kind == 3) b = b ^ 8'($urandom_range(1, 255));
        step(1'b1, b, (kind == 4 && i == 5) || (kind == 5 && i == NB));
      end
      idle(int'($urandom_range(0, 2)));
    end

    idle(2);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cfg_frame_loader.md
Name: cfg_frame_loader

Overview:
- Configuration sequencer between the UART byte receiver and the fabric_2x2 configuration input.
- Receives a framed configuration packet byte-by-byte: sync byte, payload, check byte.
- Assembles CFG_BITS bits in a staging register and verifies the check byte.
- Atomically commits the staged bits to the fabric shadow register; asserts cfg_valid_o, which gates the fabric output at top level.

Parameters:
- CFG_BITS, 52: configuration width; payload bytes NBYTES = ceil(CFG_BITS/8) = 7.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CYCLES, 20000: maximum clk_i cycles between accepted bytes inside a frame. 0 disables the timeout.

Ports:
- clk_i, input, 1: system clock.
- rst_i, input, 1: asynchronous active-high reset.
- rx_valid_i, input, 1: one-cycle strobe, new received byte on rx_data_i.
- rx_data_i, input, 8: received byte.
- rx_err_i, input, 1: one-cycle strobe, UART framing error.
- cfg_bits_o, output, CFG_BITS: committed configuration to the fabric.
- cfg_valid_o, output, 1: committed configuration is valid.
- cfg_load_o, output, 1: one-cycle pulse on the commit cycle.
- cfg_error_o, output, 1: sticky error flag.
- busy_o, output, 1: frame reception in progress.

Behaviour:
- Clocking and reset: one clock domain. rst_i asynchronously clears all state. Reset values: cfg_bits_o = 0, cfg_valid_o = 0, cfg_load_o = 0, cfg_error_o = 0, busy_o = 0, FSM = IDLE.
- Reset mid-frame: frame is discarded, no commit.
- FSM states: IDLE, PAYLOAD, CHECK.
- IDLE:
  - rx_valid_i with rx_data_i == SYNC_BYTE -> PAYLOAD. Byte index = 0, running check = 0, cfg_valid_o cleared.
  - Any other byte is ignored.
  - rx_err_i is ignored.
- PAYLOAD:
  - Each rx_valid_i stores rx_data_i into staging bits [8*idx+7 : 8*idx], little-endian, first payload byte = bits [7:0].
  - Bits at positions >= CFG_BITS in the last byte are discarded but still included in the check.
  - Check update: chk = chk XOR byte.
  - After byte NBYTES-1 -> CHECK.
  - A payload byte equal to SYNC_BYTE is data; it does not resync.
- CHECK:
  - rx_valid_i with rx_data_i == chk -> commit, then IDLE.
  - Mismatch -> cfg_error_o = 1, no commit, cfg_valid_o stays 0, then IDLE.
- Commit: registered on the cycle after the check byte strobe. Latency 1 cycle:
  - cfg_bits_o <= staging.
  - cfg_valid_o = 1.
  - cfg_load_o pulses for exactly 1 cycle.
  - cfg_error_o cleared.
- Errors and timeout in PAYLOAD or CHECK:
  - rx_err_i -> abort to IDLE with cfg_error_o = 1.
  - rx_err_i and rx_valid_i in the same cycle: the error wins and the byte is discarded.
  - Inter-byte counter resets on every accepted byte. Reaching TIMEOUT_CYCLES -> abort to IDLE with cfg_error_o = 1.
  - Counter width is $clog2(TIMEOUT_CYCLES+1); it saturates and does not wrap.
- Output stability: cfg_bits_o changes only on commit; a failed frame leaves the old bits in place but cfg_valid_o = 0.
- busy_o = 1 in PAYLOAD and CHECK.
- No backpressure: every byte is consumed in the cycle it arrives.

Optional Feature:
- Macro: CFG_LOADER_CRC8_EN.
- Defined: the check is CRC-8, polynomial 0x07, init 0x00, MSB-first, computed over the payload bytes only; the check byte must equal the final CRC.
- Undefined: the check is the XOR of the payload bytes.
- Frame format and timing are identical in both builds.

Decomposition:
- Package cfg_loader_pkg holds:
  - FSM state typedef (IDLE/PAYLOAD/CHECK).
  - SYNC_BYTE default.
  - CRC8_POLY = 8'h07.
  - Function for NBYTES.
- One sub-module, cfg_chk_step: combinational next-check-value from (chk, byte). Its XOR or CRC-8 implementation is selected by CFG_LOADER_CRC8_EN.

Test Plan:
- Reset: rst_i pulsed mid-simulation -> all outputs 0, FSM IDLE.
- Good frame, XOR build: A5 01 02 03 04 05 06 0F 08 -> one cycle after the 08 strobe:
  - cfg_bits_o = 52'hF_0605_0403_0201.
  - cfg_valid_o = 1, cfg_load_o high for exactly 1 cycle.
  - cfg_error_o = 0.
- Bad check: same frame ending 09 -> cfg_error_o = 1, cfg_valid_o = 0, cfg_bits_o unchanged, no load pulse.
- Idle noise and resync: 00 FF 5A, then the good frame -> noise ignored, commit as in the good-frame case; a payload byte of A5 is stored as data.
- Timeout: A5 01 02 03, then silence for TIMEOUT_CYCLES cycles -> cfg_error_o = 1, busy_o = 0. A following good frame clears the error and commits.
- Mid-frame abort: rx_err_i during PAYLOAD -> error, IDLE. rst_i asserted after A5 01 -> no commit, all outputs 0.
